sound_mixer_dac: RTL and testbench

Stereo mixer and 1-bit DAC for the Game Boy sound controller. It sits directly downstream of the four channel generators, including SoundCtrlChannel2.
- On each sample tick it captures the channel amplitudes and routes them left/right per NR51.
- It scales each side by the NR50 master volume and publishes registered 10-bit stereo samples.
- It drives a first-order sigma-delta modulator per side, producing PDM pins for an external RC filter.
- NR52 bit 7 gates the whole block.

---
 rtl/sound_mixer_dac.sv | 81 ++++++++
 tb/tb_sound_mixer_dac.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sound_mixer_dac.sv
// sound_mixer_dac: NR51 stereo routing, NR50 volume scaling and per-side
// first-order sigma-delta PDM, all gated by the NR52 master enable.
module sound_mixer_dac #(
    parameter int CH_W = 5
) (
    input  logic            iClock,
    input  logic            iReset,
    input  logic            iSampleTick,
    input  logic [CH_W-1:0] iCh1,
    input  logic [CH_W-1:0] iCh2,
    input  logic [CH_W-1:0] iCh3,
    input  logic [CH_W-1:0] iCh4,
    input  logic [3:0]      iChanOn,
    input  logic [7:0]      iNR50,
    input  logic [7:0]      iNR51,
    input  logic [7:0]      iNR52,
    output logic [CH_W+4:0] oLeft,
    output logic [CH_W+4:0] oRight,
    output logic            oSampleValid,
    output logic            oPdmLeft,
    output logic            oPdmRight
);
    localparam int SW = CH_W + 2;
    localparam int OW = CH_W + 5;

    logic [CH_W-1:0] ch [4];
    logic [SW-1:0]   sum_l, sum_r, s1_l, s1_r;
    logic            s1_v;
    logic [OW-1:0]   vol_l, vol_r, acc_l, acc_r;
    logic [OW:0]     sd_l, sd_r;

    assign ch[0] = iCh1;
    assign ch[1] = iCh2;
    assign ch[2] = iCh3;
    assign ch[3] = iCh4;

    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int n = 0; n < 4; n++) begin
            sum_l = sum_l + ((iNR51[4+n] & iChanOn[n]) ? SW'(ch[n]) : '0);
            sum_r = sum_r + ((iNR51[n] & iChanOn[n]) ? SW'(ch[n]) : '0);
        end
    end

    assign vol_l = OW'({1'b0, iNR50[6:4]} + 4'd1);
    assign vol_r = OW'({1'b0, iNR50[2:0]} + 4'd1);
    // The carry out of the wrapping accumulator is the PDM bit.
    assign sd_l  = {1'b0, acc_l} + {1'b0, oLeft};
    assign sd_r  = {1'b0, acc_r} + {1'b0, oRight};

    always_ff @(posedge iClock) begin
        if (iReset || !iNR52[7]) begin
            s1_l         <= '0;
            s1_r         <= '0;
            s1_v         <= 1'b0;
            oLeft        <= '0;
            oRight       <= '0;
            oSampleValid <= 1'b0;
            acc_l        <= '0;
            acc_r        <= '0;
            oPdmLeft     <= 1'b0;
            oPdmRight    <= 1'b0;
        end else begin
            s1_v         <= iSampleTick;
            oSampleValid <= s1_v;
            if (iSampleTick) begin
                s1_l <= sum_l;
                s1_r <= sum_r;
            end
            if (s1_v) begin
                oLeft  <= OW'(s1_l) * vol_l;
                oRight <= OW'(s1_r) * vol_r;
            end
            acc_l     <= sd_l[OW-1:0];
            acc_r     <= sd_r[OW-1:0];
            oPdmLeft  <= sd_l[OW];
            oPdmRight <= sd_r[OW];
        end
    end
endmodule

// File: tb/tb_sound_mixer_dac.sv
// tb_sound_mixer_dac: directed checks of routing, volume, pipelining,
// sigma-delta density and master-disable behaviour.
module tb_sound_mixer_dac;
    logic       iClock = 1'b0;
    logic       iReset = 1'b1;
    logic       iSampleTick = 1'b0;
    logic [4:0] iCh1 = '0, iCh2 = '0, iCh3 = '0, iCh4 = '0;
    logic [3:0] iChanOn = '0;
    logic [7:0] iNR50 = '0, iNR51 = '0, iNR52 = '0;
    logic [9:0] oLeft, oRight;
    logic       oSampleValid, oPdmLeft, oPdmRight;
    int checks = 0;
    int errors = 0;

    sound_mixer_dac #(.CH_W(5)) dut (
        .iClock(iClock), .iReset(iReset), .iSampleTick(iSampleTick),
        .iCh1(iCh1), .iCh2(iCh2), .iCh3(iCh3), .iCh4(iCh4),
        .iChanOn(iChanOn), .iNR50(iNR50), .iNR51(iNR51), .iNR52(iNR52),
        .oLeft(oLeft), .oRight(oRight), .oSampleValid(oSampleValid),
        .oPdmLeft(oPdmLeft), .oPdmRight(oPdmRight)
    );

    always #5 iClock = ~iClock;

    task automatic cyc(input int n);
        repeat (n) @(negedge iClock);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Tick at this negedge; returns at the negedge where the sample is visible.
    task automatic tick_and_wait;
        iSampleTick = 1'b1;
        cyc(1);
        iSampleTick = 1'b0;
        cyc(1);
    endtask

    task automatic chk_sample(input string tag, input int l, input int r);
        chk({tag, "_valid"}, int'(oSampleValid), 1);
        chk({tag, "_left"}, int'(oLeft), l);
        chk({tag, "_right"}, int'(oRight), r);
    endtask

    initial begin
        int ones, prev, alt_err;
        iNR52 = 8'h80;
        cyc(2);
        chk("rst_valid", int'(oSampleValid), 0);
        chk("rst_left", int'(oLeft), 0);
        chk("rst_right", int'(oRight), 0);
        chk("rst_pdm", int'({oPdmLeft, oPdmRight}), 0);
        iReset = 1'b0;

        // 1: ch2 to both sides, full volume
        iNR50 = 8'h77; iNR51 = 8'h22; iChanOn = 4'hF; iCh2 = 5'd31;
        cyc(1);
        chk("t1_pre_valid", int'(oSampleValid), 0);
        iSampleTick = 1'b1;
        cyc(1);
        iSampleTick = 1'b0;
        chk("t1_e1_valid", int'(oSampleValid), 0);
        cyc(1);
        chk_sample("t1", 248, 248);
        cyc(1);
        chk("t1_fall", int'(oSampleValid), 0);
        chk("t1_hold", int'(oLeft), 248);

        // 2: left only, then lower left volume
        iNR51 = 8'h20; iNR50 = 8'h70;
        tick_and_wait();
        chk_sample("t2a", 248, 0);
        iNR50 = 8'h30;
        tick_and_wait();
        chk_sample("t2b", 124, 0);

        // channel changes between ticks are ignored
        iCh2 = 5'd7;
        cyc(3);
        chk("t2_hold", int'(oLeft), 124);

        // 3: all channels, then ch2 inactive; mixed volumes
        iCh1 = 5'd31; iCh2 = 5'd31; iCh3 = 5'd31; iCh4 = 5'd31;
        iNR51 = 8'hFF; iNR50 = 8'h77;
        tick_and_wait();
        chk_sample("t3a", 992, 992);
        iChanOn = 4'hD;
        tick_and_wait();
        chk_sample("t3b", 744, 744);
        iChanOn = 4'hF; iNR51 = 8'h81; iNR50 = 8'hA9;
        tick_and_wait();
        chk_sample("t3c", 93, 62);

        // 4: oLeft = 512 from (31+31+2) x 8; start from zeroed accumulators
        iReset = 1'b1;
        cyc(1);
        iReset = 1'b0;
        iCh1 = 5'd31; iCh2 = 5'd31; iCh3 = 5'd2; iCh4 = 5'd0;
        iNR51 = 8'h70; iNR50 = 8'h70;
        tick_and_wait();
        chk_sample("t4", 512, 0);
        cyc(2);
        ones = 0; alt_err = 0; prev = int'(oPdmLeft);
        for (int i = 0; i < 1024; i++) begin
            cyc(1);
            ones += int'(oPdmLeft);
            if (int'(oPdmLeft) == prev) alt_err++;
            prev = int'(oPdmLeft);
        end
        chk("t4_ones", ones, 512);
        chk("t4_alternate", alt_err, 0);
        iChanOn = 4'h0;
        tick_and_wait();
        chk_sample("t4z", 0, 0);
        cyc(2);
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            cyc(1);
            ones += int'(oPdmLeft) + int'(oPdmRight);
        end
        chk("t4z_ones", ones, 0);

        // 5: back-to-back ticks
        iChanOn = 4'hF; iNR50 = 8'h00; iNR51 = 8'h22;
        iCh1 = '0; iCh3 = '0;
        iSampleTick = 1'b1; iCh2 = 5'd1;
        cyc(1);
        iCh2 = 5'd2;
        cyc(1);
        chk_sample("t5a", 1, 1);
        iCh2 = 5'd3;
        cyc(1);
        chk_sample("t5b", 2, 2);
        iSampleTick = 1'b0;
        cyc(1);
        chk_sample("t5c", 3, 3);
        cyc(1);
        chk("t5_fall", int'(oSampleValid), 0);

        // 6: master disable with a sample in flight
        iNR50 = 8'h77; iCh2 = 5'd31;
        tick_and_wait();
        chk_sample("t6_pre", 248, 248);
        iCh2 = 5'd10;
        iSampleTick = 1'b1;
        cyc(1);
        iSampleTick = 1'b0;
        iNR52 = 8'h00;
        cyc(1);
        chk("t6_off_valid", int'(oSampleValid), 0);
        chk("t6_off_left", int'(oLeft), 0);
        chk("t6_off_right", int'(oRight), 0);
        chk("t6_off_pdm", int'({oPdmLeft, oPdmRight}), 0);
        iSampleTick = 1'b1;
        cyc(2);
        iSampleTick = 1'b0;
        iNR52 = 8'h80;
        cyc(3);
        chk("t6_on_valid", int'(oSampleValid), 0);
        chk("t6_on_left", int'(oLeft), 0);
        tick_and_wait();
        chk_sample("t6_resume", 80, 80);

        // tick in the cycle the enable falls is dropped
        iCh2 = 5'd5;
        iSampleTick = 1'b1; iNR52 = 8'h00;
        cyc(1);
        iSampleTick = 1'b0; iNR52 = 8'h80;
        cyc(1);
        chk("dis_tick_v1", int'(oSampleValid), 0);
        cyc(1);
        chk("dis_tick_v2", int'(oSampleValid), 0);
        chk("dis_tick_left", int'(oLeft), 0);

        // reset mid-pipeline, and reset coincident with a tick
        tick_and_wait();
        chk_sample("rst_pre", 40, 40);
        iSampleTick = 1'b1;
        cyc(1);
        iSampleTick = 1'b0; iReset = 1'b1;
        cyc(1);
        chk("rst_mid_valid", int'(oSampleValid), 0);
        chk("rst_mid_left", int'(oLeft), 0);
        iSampleTick = 1'b1;
        cyc(1);
        iSampleTick = 1'b0; iReset = 1'b0;
        cyc(1);
        chk("rst_tick_v1", int'(oSampleValid), 0);
        cyc(1);
        chk("rst_tick_v2", int'(oSampleValid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
